// File: rtl/ext_euclid_pkg.sv
// rtl/ext_euclid_pkg.sv - FSM states and coefficient width helper for the modular-inverse engine
package ext_euclid_pkg;

  typedef enum logic [2:0] {
    st_idle,
    st_div,
    st_update,
    st_final,
    st_done
  } state_t;

  // Bezout coefficients stay within +/-m, so a sign bit plus one headroom bit suffices.
  function automatic int coef_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/euclid_divstep.sv
// rtl/euclid_divstep.sv - sequential restoring divider with Horner q*t1 accumulator
module euclid_divstep
  import ext_euclid_pkg::*;
#(
  parameter int WIDTH = 512,
  localparam int CW = coef_w(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  input  logic signed [CW-1:0] t1,
  output logic                 busy,
  output logic [WIDTH-1:0]     rem,
  output logic signed [CW-1:0] acc
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     quo_sh;
  logic [WIDTH-1:0]     dsr;
  logic [WIDTH-1:0]     rem_r;
  logic [WIDTH-1:0]     diff;
  logic [WIDTH-1:0]     rem_n;
  logic [WIDTH:0]       trial;
  logic signed [CW-1:0] t1_r;
  logic signed [CW-1:0] acc_r;
  logic signed [CW-1:0] acc_n;
  logic                 qbit;

  always_comb begin
    trial = {rem_r, quo_sh[WIDTH-1]};
    qbit  = trial >= {1'b0, dsr};
    diff  = trial[WIDTH-1:0] - dsr;
    rem_n = qbit ? diff : trial[WIDTH-1:0];
    acc_n = (acc_r <<< 1) + (qbit ? t1_r : '0);
  end

  // busy drops during the final step so the caller can leave DIV on that same edge.
  assign busy = (cnt[CNT_W-1:1] != '0);
  assign rem  = rem_r;
  assign acc  = acc_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      quo_sh <= '0;
      dsr    <= '0;
      rem_r  <= '0;
      t1_r   <= '0;
      acc_r  <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(WIDTH);
      quo_sh <= dividend;
      dsr    <= divisor;
      rem_r  <= '0;
      t1_r   <= t1;
      acc_r  <= '0;
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
      quo_sh <= quo_sh << 1;
      rem_r  <= rem_n;
      acc_r  <= acc_n;
    end
  end

endmodule

// File: rtl/mod_inverse_engine.sv
// rtl/mod_inverse_engine.sv - handshaked extended-Euclid modular inverse engine
module mod_inverse_engine
  import ext_euclid_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Multiplicative_Num,
  input  logic [WIDTH-1:0] Modular,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Multiplicative_Inv_Num,
  output logic [WIDTH-1:0] Gcd,
  output logic             error
);

  localparam int CW = coef_w(WIDTH);
  localparam logic [WIDTH-1:0]     ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] T_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [WIDTH-1:0]     r0, r1, m_reg;
  logic signed [CW-1:0] t0, t1;
  logic                 accept, shortcut, fin_err;
  logic [WIDTH-1:0]     fin_inv;
  logic                 div_start, div_busy;
  logic [WIDTH-1:0]     div_dividend, div_divisor, div_rem;
  logic signed [CW-1:0] div_t1, div_acc, t1_next;

  assign in_ready  = (state == st_idle) && !areset;
  assign out_valid = (state == st_done);
  assign accept    = in_valid && in_ready;
  assign shortcut  = (Modular[WIDTH-1:1] == '0) || (Multiplicative_Num == '0);
  assign t1_next   = t0 - div_acc;
  assign fin_err   = (r0 != ONE) || (m_reg[WIDTH-1:1] == '0);
  // Adding m in WIDTH-bit arithmetic is exact because the result lands in [0, m).
  assign fin_inv   = t0[CW-1] ? (t0[WIDTH-1:0] + m_reg) : t0[WIDTH-1:0];

  // The divider is launched with the values r0/r1/t1 are about to take.
  always_comb begin
    state_n      = state;
    div_start    = 1'b0;
    div_dividend = Modular;
    div_divisor  = Multiplicative_Num;
    div_t1       = T_ONE;
    case (state)
      st_idle: begin
        if (accept) begin
          if (shortcut) begin
            state_n = st_final;
          end else begin
            state_n   = st_div;
            div_start = 1'b1;
          end
        end
      end
      st_div: begin
        if (!div_busy) state_n = st_update;
      end
      st_update: begin
        div_dividend = r1;
        div_divisor  = div_rem;
        div_t1       = t1_next;
        if (div_rem == '0) begin
          state_n = st_final;
        end else begin
          state_n   = st_div;
          div_start = 1'b1;
        end
      end
      st_final: state_n = st_done;
      st_done: begin
        if (out_ready) state_n = st_idle;
      end
      default: state_n = st_idle;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state                  <= st_idle;
      r0                     <= '0;
      r1                     <= '0;
      m_reg                  <= '0;
      t0                     <= '0;
      t1                     <= '0;
      Gcd                    <= '0;
      error                  <= 1'b0;
      Multiplicative_Inv_Num <= '0;
    end else begin
      state <= state_n;
      case (state)
        st_idle: begin
          if (accept) begin
            m_reg <= Modular;
            r0    <= Modular;
            r1    <= Multiplicative_Num;
            t0    <= '0;
            t1    <= T_ONE;
          end
        end
        st_update: begin
          r0 <= r1;
          r1 <= div_rem;
          t0 <= t1;
          t1 <= t1_next;
        end
        st_final: begin
          Gcd                    <= r0;
          error                  <= fin_err;
          Multiplicative_Inv_Num <= fin_err ? '0 : fin_inv;
        end
        default: ;
      endcase
    end
  end

  euclid_divstep #(.WIDTH(WIDTH)) u_divstep (
    .clk      (aclk),
    .reset    (areset),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .t1       (div_t1),
    .busy     (div_busy),
    .rem      (div_rem),
    .acc      (div_acc)
  );

endmodule

// File: tb/tb_mod_inverse_engine.sv
// tb/tb_mod_inverse_engine.sv - directed and random checks of mod_inverse_engine
module tb_mod_inverse_engine;

  localparam int W       = 512;
  localparam int WS      = 64;
  localparam int LAT_MAX = 10000;

  logic         aclk = 1'b0;
  logic         areset;
  logic         in_valid, in_ready, out_valid, out_ready, error;
  logic [W-1:0] a_in, m_in, inv, gcd;
  logic          in_valid_s, in_ready_s, out_valid_s, out_ready_s, error_s;
  logic [WS-1:0] a_s, m_s, inv_s, gcd_s;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  mod_inverse_engine #(.WIDTH(W)) dut (
    .aclk                   (aclk),
    .areset                 (areset),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .Multiplicative_Num     (a_in),
    .Modular                (m_in),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .Multiplicative_Inv_Num (inv),
    .Gcd                    (gcd),
    .error                  (error)
  );

  mod_inverse_engine #(.WIDTH(WS)) dut_s (
    .aclk                   (aclk),
    .areset                 (areset),
    .in_valid               (in_valid_s),
    .in_ready               (in_ready_s),
    .Multiplicative_Num     (a_s),
    .Modular                (m_s),
    .out_valid              (out_valid_s),
    .out_ready              (out_ready_s),
    .Multiplicative_Inv_Num (inv_s),
    .Gcd                    (gcd_s),
    .error                  (error_s)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] m;
    logic [W-1:0] inv;
    logic [W-1:0] gcd;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] m, input int hold, input bit poke,
                        output logic [W-1:0] inv_o, output logic [W-1:0] gcd_o, output logic err_o,
                        output int lat);
    int   n;
    logic stable, blocked;
    @(negedge aclk);
    a_in      = a;
    m_in      = m;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    #1;
    in_valid = 1'b0;
    a_in     = '1;
    m_in     = '1;
    blocked  = 1'b1;
    lat      = 0;
    do begin
      @(posedge aclk);
      #1;
      lat++;
      if (poke && lat == 20) begin
        in_valid = 1'b1;
        a_in     = W'(6);
        m_in     = W'(640);
      end
      if (poke && lat > 20 && lat <= 40 && in_ready) blocked = 1'b0;
      if (poke && lat == 40) in_valid = 1'b0;
    end while (!out_valid && lat < LAT_MAX);
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: got no out_valid, expected one within %0d cycles", LAT_MAX);
    end
    if (poke) chk("busy_blocked", blocked, 1);
    inv_o  = inv;
    gcd_o  = gcd;
    err_o  = error;
    stable = 1'b1;
    repeat (hold) begin
      @(posedge aclk);
      #1;
      if (!out_valid || inv !== inv_o || gcd !== gcd_o || error !== err_o) stable = 1'b0;
    end
    if (hold > 0) chk("hold_stable", stable, 1);
    out_ready = 1'b1;
    @(posedge aclk);
    #1;
    chk("ready_after_hs", {in_ready, out_valid}, 2'b10);
  endtask

  task automatic run64(input logic [WS-1:0] a, input logic [WS-1:0] m,
                       output logic [WS-1:0] inv_o, output logic [WS-1:0] gcd_o, output logic err_o);
    int n;
    @(negedge aclk);
    a_s        = a;
    m_s        = m;
    in_valid_s = 1'b1;
    @(posedge aclk);
    #1;
    in_valid_s = 1'b0;
    n = 0;
    do begin
      @(posedge aclk);
      #1;
      n++;
    end while (!out_valid_s && n < LAT_MAX);
    if (!out_valid_s) begin
      checks++;
      errors++;
      $display("FAIL rand_timeout: got no out_valid, expected one within %0d cycles", LAT_MAX);
    end
    inv_o = inv_s;
    gcd_o = gcd_s;
    err_o = error_s;
    @(posedge aclk);
    #1;
  endtask

  function automatic void ref_model(input logic [WS-1:0] a, input logic [WS-1:0] m,
                                    output logic [WS-1:0] inv_o, output logic [WS-1:0] gcd_o);
    logic [WS-1:0]        r0, r1, q, rm;
    logic signed [129:0]  c0, c1, cn;
    r0 = m;
    r1 = a;
    c0 = 130'sd0;
    c1 = 130'sd1;
    while (r1 != '0) begin
      q  = r0 / r1;
      rm = r0 % r1;
      r0 = r1;
      r1 = rm;
      cn = c0 - $signed({66'd0, q}) * c1;
      c0 = c1;
      c1 = cn;
    end
    gcd_o = r0;
    if (c0 < 0) c0 = c0 + $signed({66'd0, m});
    inv_o = c0[WS-1:0];
  endfunction

  initial begin
    logic [W-1:0]  g_inv, g_gcd;
    logic          g_err;
    int            lat;
    logic          seen;
    logic [WS-1:0] ra, rm, ei, eg, si, sg;
    logic          se;
    logic [127:0]  prod;
    int            tries;

    vecs[0] = '{W'(3),   W'(640),  W'(427),  W'(1),   1'b0, 1027};
    vecs[1] = '{W'(17),  W'(3120), W'(2753), W'(1),   1'b0, 2053};
    vecs[2] = '{W'(643), W'(640),  W'(427),  W'(1),   1'b0, 2053};
    vecs[3] = '{W'(6),   W'(640),  W'(0),    W'(2),   1'b1, 1540};
    vecs[4] = '{W'(5),   W'(1),    W'(0),    W'(1),   1'b1, 1};
    vecs[5] = '{W'(0),   W'(640),  W'(0),    W'(640), 1'b1, 1};
    vecs[6] = '{W'(7),   W'(0),    W'(0),    W'(0),   1'b1, 1};
    vecs[7] = '{W'(1),   W'(2),    W'(1),    W'(1),   1'b0, 514};
    vecs[8] = '{W'(640), W'(640),  W'(0),    W'(640), 1'b1, 514};

    areset      = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    a_in        = '0;
    m_in        = '0;
    in_valid_s  = 1'b0;
    out_ready_s = 1'b1;
    a_s         = '0;
    m_s         = '0;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_outputs", {out_valid, error}, 2'b00);
    chk("rst_inv", inv, 0);
    chk("rst_gcd", gcd, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    chk("post_rst_ready", in_ready, 1);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].m, 0, 1'b0, g_inv, g_gcd, g_err, lat);
      chk($sformatf("v%0d_inv", i), g_inv, vecs[i].inv);
      chk($sformatf("v%0d_gcd", i), g_gcd, vecs[i].gcd);
      chk($sformatf("v%0d_err", i), g_err, vecs[i].err);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
    end

    // Backpressure for 50 cycles plus a competing request while dividing.
    run_op(W'(3), W'(640), 50, 1'b1, g_inv, g_gcd, g_err, lat);
    chk("bp_inv", g_inv, 427);
    chk("bp_gcd", g_gcd, 1);
    chk("bp_err", g_err, 0);

    // Abort mid-DIV with a one-cycle reset.
    @(negedge aclk);
    a_in     = W'(3);
    m_in     = W'(640);
    in_valid = 1'b1;
    @(posedge aclk);
    #1;
    in_valid = 1'b0;
    repeat (100) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    chk("abort_ready_low", in_ready, 0);
    chk("abort_gcd_cleared", gcd, 0);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    chk("abort_ready_high", in_ready, 1);
    seen = 1'b0;
    repeat (1100) begin
      @(posedge aclk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_out_valid", seen, 0);
    run_op(W'(3), W'(640), 0, 1'b0, g_inv, g_gcd, g_err, lat);
    chk("abort_rerun_inv", g_inv, 427);
    chk("abort_rerun_lat", lat, 1027);

    for (int k = 0; k < 6; k++) begin
      tries = 0;
      do begin
        rm = {$urandom, $urandom};
        ra = {$urandom, $urandom};
        ref_model(ra, rm, ei, eg);
        tries++;
      end while ((eg != 64'd1 || rm < 64'd2 || ra == '0) && tries < 200);
      run64(ra, rm, si, sg, se);
      prod = ({64'd0, si} * {64'd0, ra}) % {64'd0, rm};
      chk($sformatf("rand%0d_inv", k), W'(si), W'(ei));
      chk($sformatf("rand%0d_prod", k), W'(prod), 1);
      chk($sformatf("rand%0d_lt_m", k), (si < rm), 1);
      chk($sformatf("rand%0d_gcd_err", k), {W'(sg), se}, {W'(1), 1'b0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_inverse_engine.md
# mod_inverse_engine

Parametrised, handshaked modular-inverse engine for the RSA key-generation path. Accepts an operand `a` and modulus `m` over valid/ready and runs the iterative extended Euclidean algorithm. Returns `a^-1 mod m`, `gcd(a,m)` and an error flag on valid/ready. It supersedes the free-running ext_euclidean core by adding flow control, arbitrary `a` (including `a >= m`), non-coprime detection, and a bounded, documented latency.

## Interface
- `WIDTH`, 512, operand/modulus width in bits
- `aclk`  in  1  clock, all logic on rising edge
- `areset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  engine idle and able to accept
- `Multiplicative_Num`  in  WIDTH  operand `a`, unsigned
- `Modular`  in  WIDTH  modulus `m`, unsigned
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `Multiplicative_Inv_Num`  out  WIDTH  `a^-1 mod m`, in `[0, m)`; 0 on error
- `Gcd`  out  WIDTH  `gcd(a, m)` as computed (final `r0`)
- `error`  out  1  no inverse exists (`gcd != 1` or `m < 2`)

## Operation
- One clock (`aclk`); reset is synchronous and active-high (`areset`).
- State registers:
  - remainders `r0`, `r1`: WIDTH bits each.
  - coefficients `t0`, `t1`: signed, WIDTH+2 bits each.
  - invariant: `r_i ≡ t_i·a (mod m)`.
  - `|t| <= m`, so no overflow is possible.
- FSM states: IDLE, DIV, UPDATE, FINAL, DONE.
- IDLE: `in_ready` = 1. On `in_valid && in_ready`:
  - latch `m`; load `r0=m`, `r1=a`, `t0=0`, `t1=1`.
  - if `m < 2` or `a == 0`, go to FINAL; otherwise go to DIV.
- DIV: WIDTH cycles of restoring division, `r0 / r1`, one quotient bit per cycle, MSB first.
  - in parallel, Horner accumulation `acc = 2·acc + (qbit ? t1 : 0)`, giving `acc = q·t1` without a multiplier.
- UPDATE (1 cycle):
  - `r0 <= r1`, `r1 <= rem`.
  - `t0 <= t1`, `t1 <= t0 − acc`.
  - if `rem == 0`, go to FINAL; otherwise go to DIV.
- FINAL (1 cycle):
  - `Gcd <= r0`.
  - `error <= (r0 != 1) || (m < 2)`.
  - `Multiplicative_Inv_Num <= error ? 0 : (t0 < 0 ? t0 + m : t0)`.
  - go to DONE.
- DONE: `out_valid` = 1; outputs held stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.
- `a >= m` needs no special handling: the first step yields `q = 0` and swaps the operands.
- `in_valid` while busy is ignored (`in_ready` = 0); input ports are not sampled after acceptance.

## Timing
- Reset: while `areset` is high and on the first cycle after it, state is IDLE.
  - `in_ready` is 0 during reset and 1 on the first cycle after.
  - `out_valid`, `error` = 0; `Multiplicative_Inv_Num`, `Gcd` = 0; all datapath registers cleared.
- Reset mid-operation aborts the computation on that edge; no `out_valid` is produced.
- Latency, with accept edge `e0` and `S` division steps:
  - `out_valid` rises after edge `e0 + S·(WIDTH+1) + 1`.
  - shortcut cases (`m < 2` or `a == 0`): after `e0 + 1`.
- `S <= ceil(1.45·WIDTH) + 2` (Lamé bound), so worst case ≈ `1.45·WIDTH²` cycles.
- Throughput: one operation in flight.
- Back-to-back: `in_ready` rises the cycle after the output handshake.
- Output backpressure: `out_valid` and data hold indefinitely while `out_ready` = 0.

## Structure
- `ext_euclid_pkg`: FSM state enum (`st_idle`, `st_div`, `st_update`, `st_final`, `st_done`) and the function `coef_w(WIDTH) = WIDTH + 2`.
- Sub-module `euclid_divstep`:
  - purpose: sequential restoring divider plus Horner `q·t1` accumulator.
  - ports: `start`, `dividend`, `divisor`, `t1`, `busy`, `rem`, `acc`.
  - fixed WIDTH-cycle run.
- Top level holds the handshake, the FSM, the `r`/`t` registers and the final reduction.

## Test plan
- `a=3`, `m=640` → inverse 427, `Gcd` 1, `error` 0; `out_valid` after 2·(WIDTH+1)+1 cycles (1027 at WIDTH=512).
- `a=17`, `m=3120` → inverse 2753, `Gcd` 1, `error` 0.
- `a=643`, `m=640` → inverse 427 (operand ≥ modulus). `a=6`, `m=640` → inverse 0, `Gcd` 2, `error` 1.
- `m=1`, `a=5` → `error` 1, `Gcd` 1, inverse 0 after 1 cycle. `a=0`, `m=640` → `error` 1, `Gcd` 640.
- Backpressure and busy input: hold `out_ready` = 0 for 50 cycles → outputs stable; assert `in_valid` during DIV → no acceptance and no corruption.
- Reset mid-DIV: assert `areset` for 1 cycle → no `out_valid`; `in_ready` = 1 next cycle. A new request, `a=3`, `m=640`, then yields 427.
- Random coprime pairs at WIDTH=64 → check `(inv·a) mod m == 1` and `inv < m`, compared against a reference model.
